// File: rtl/decodificador_bcd_seq_if.sv
// Start/done handshake bundle between a binary producer and the BCD converter.
interface decodificador_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/decodificador_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with start/done handshake, busy flag and overflow for values beyond DIGITS.
module decodificador_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  decodificador_bcd_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sh;
  logic [BCD_W-1:0]   r_w;
  logic               r_ovf_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_w_nxt;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic               w_carry;
  logic               w_last;

  // Per-digit correction; digits never carry into each other.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_adj    = add3(r_w);
  assign w_w_nxt  = {w_adj[BCD_W-2:0], r_sh[WIDTH-1]};
  assign w_sh_nxt = {r_sh[WIDTH-2:0], 1'b0};
  assign w_carry  = w_adj[BCD_W-1];
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Control and result registers; the result is loaded on entry to DONE so it
  // is visible together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_ovf_acc  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt == S_SHIFT);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_SHIFT: begin
          r_ovf_acc <= r_ovf_acc | w_carry;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd      <= w_w_nxt;
            r_overflow <= r_ovf_acc | w_carry;
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_sh <= bus.bin;
      r_w  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sh <= w_sh_nxt;
      r_w  <= w_w_nxt;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_decodificador_bcd_seq.sv
// Bench for decodificador_bcd_seq: three parameterisations share clock and
// reset; expected results are queued at start and checked on each done.
module tb_decodificador_bcd_seq;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct { logic [11:0] bcd; logic ovf; int due; } exp_t;
  typedef struct { int bin; logic [11:0] bcd; logic ovf; } vec_t;

  exp_t q4[$];
  exp_t q83[$];
  exp_t q82[$];
  vec_t v83[3];
  vec_t v82[3];

  decodificador_bcd_seq_if #(.WIDTH(4), .DIGITS(2)) if4 ();
  decodificador_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) if83 ();
  decodificador_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) if82 ();

  decodificador_bcd_seq #(.WIDTH(4), .DIGITS(2)) u4  (.clk(clk), .rst(rst), .bus(if4));
  decodificador_bcd_seq #(.WIDTH(8), .DIGITS(3)) u83 (.clk(clk), .rst(rst), .bus(if83));
  decodificador_bcd_seq #(.WIDTH(8), .DIGITS(2)) u82 (.clk(clk), .rst(rst), .bus(if82));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v, input int digits);
    logic [11:0] r;
    int m;
    m = 1;
    for (int d = 0; d < digits; d++) m = m * 10;
    v = v % m;
    r = '0;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Scoreboard: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (if4.done === 1'b1) begin
      if (q4.size() == 0) chk("u4 unexpected done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("u4 bcd", 32'(if4.bcd), 32'(e.bcd));
        chk("u4 ovf", 32'(if4.overflow), 32'(e.ovf));
        chk("u4 latency", cyc, e.due);
        chk("u4 busy at done", 32'(if4.busy), 32'd0);
      end
    end
    if (if83.done === 1'b1) begin
      if (q83.size() == 0) chk("u83 unexpected done", 32'd1, 32'd0);
      else begin
        e = q83.pop_front();
        chk("u83 bcd", 32'(if83.bcd), 32'(e.bcd));
        chk("u83 ovf", 32'(if83.overflow), 32'(e.ovf));
        chk("u83 latency", cyc, e.due);
        chk("u83 busy at done", 32'(if83.busy), 32'd0);
      end
    end
    if (if82.done === 1'b1) begin
      if (q82.size() == 0) chk("u82 unexpected done", 32'd1, 32'd0);
      else begin
        e = q82.pop_front();
        chk("u82 bcd", 32'(if82.bcd), 32'(e.bcd));
        chk("u82 ovf", 32'(if82.overflow), 32'(e.ovf));
        chk("u82 latency", cyc, e.due);
        chk("u82 busy at done", 32'(if82.busy), 32'd0);
      end
    end
  end

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q4.size();
      1:       return q83.size();
      default: return q82.size();
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int sel, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (qsize(sel) == 0) break;
      tick(1);
    end
    chk("scoreboard drained", qsize(sel), 0);
  endtask

  task automatic run_one(input int sel, input int b, input logic [11:0] eb, input logic eo);
    exp_t e;
    tick(1);
    e.bcd = eb;
    e.ovf = eo;
    case (sel)
      0: begin if4.bin = 4'(b);  if4.start = 1'b1;  e.due = cyc + 5; q4.push_back(e);  end
      1: begin if83.bin = 8'(b); if83.start = 1'b1; e.due = cyc + 9; q83.push_back(e); end
      default: begin if82.bin = 8'(b); if82.start = 1'b1; e.due = cyc + 9; q82.push_back(e); end
    endcase
    tick(1);
    case (sel)
      0: begin if4.start = 1'b0;  if4.bin = 4'($urandom);  chk("u4 busy after start", 32'(if4.busy), 32'd1); end
      1: begin if83.start = 1'b0; if83.bin = 8'($urandom); chk("u83 busy after start", 32'(if83.busy), 32'd1); end
      default: begin if82.start = 1'b0; if82.bin = 8'($urandom); chk("u82 busy after start", 32'(if82.busy), 32'd1); end
    endcase
    wait_empty(sel, 20);
  endtask

  initial begin
    exp_t e;
    int c;
    v83[0] = '{bin: 0,   bcd: 12'h000, ovf: 1'b0};
    v83[1] = '{bin: 255, bcd: 12'h255, ovf: 1'b0};
    v83[2] = '{bin: 128, bcd: 12'h128, ovf: 1'b0};
    v82[0] = '{bin: 99,  bcd: 12'h099, ovf: 1'b0};
    v82[1] = '{bin: 100, bcd: 12'h000, ovf: 1'b1};
    v82[2] = '{bin: 199, bcd: 12'h099, ovf: 1'b1};

    rst = 1'b1;
    if4.start = 1'b0;  if4.bin = '0;
    if83.start = 1'b0; if83.bin = '0;
    if82.start = 1'b0; if82.bin = '0;
    tick(3);
    chk("reset busy", 32'(if83.busy), 32'd0);
    chk("reset done", 32'(if83.done), 32'd0);
    chk("reset bcd", 32'(if83.bcd), 32'd0);
    chk("reset overflow", 32'(if83.overflow), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_one(0, i, to_bcd(i, 2), 1'b0);
    for (int i = 0; i < 3; i++) run_one(1, v83[i].bin, v83[i].bcd, v83[i].ovf);
    for (int i = 0; i < 3; i++) run_one(2, v82[i].bin, v82[i].bcd, v82[i].ovf);

    // Second start while busy must be dropped.
    tick(1);
    if83.bin = 8'd255; if83.start = 1'b1;
    e.bcd = 12'h255; e.ovf = 1'b0; e.due = cyc + 9; q83.push_back(e);
    tick(1);
    if83.start = 1'b0;
    tick(2);
    if83.bin = 8'd7; if83.start = 1'b1;
    tick(1);
    if83.start = 1'b0;
    chk("busy during dropped start", 32'(if83.busy), 32'd1);
    wait_empty(1, 20);
    tick(15);
    chk("dropped start bcd", 32'(if83.bcd), 32'h255);

    // Reset mid-conversion abandons it without a done pulse.
    if83.bin = 8'd255; if83.start = 1'b1;
    tick(1);
    if83.start = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mid reset busy", 32'(if83.busy), 32'd0);
    chk("mid reset bcd", 32'(if83.bcd), 32'd0);
    chk("mid reset done", 32'(if83.done), 32'd0);
    rst = 1'b0;
    tick(15);
    run_one(1, 42, 12'h042, 1'b0);

    // rst and start together: nothing captured.
    rst = 1'b1; if83.bin = 8'd77; if83.start = 1'b1;
    tick(1);
    rst = 1'b0; if83.start = 1'b0;
    chk("rst+start busy", 32'(if83.busy), 32'd0);
    tick(12);
    chk("rst+start bcd", 32'(if83.bcd), 32'd0);

    // Start held high: one conversion every WIDTH+2 cycles.
    c = cyc;
    if83.bin = 8'd37; if83.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.bcd = 12'h037; e.ovf = 1'b0; e.due = c + 9 + 10 * k; q83.push_back(e);
    end
    tick(30);
    if83.start = 1'b0;
    wait_empty(1, 20);
    tick(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
